// File: rtl/seq_pattern_tx_if.sv
// Control and serial-output bundle for the seq_pattern_tx pattern transmitter.
// The master side issues commands; the slave side (the transmitter) drives the stream.
interface seq_pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             load_pat;
    logic [PAT_W-1:0] pat_in;
    logic             start;
    logic [CNT_W-1:0] reps;
    logic             abort;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             frame_end;
    logic             done;

    modport master (
        output load_pat, pat_in, start, reps, abort,
        input  out, out_valid, busy, frame_end, done
    );

    modport slave (
        input  load_pat, pat_in, start, reps, abort,
        output out, out_valid, busy, frame_end, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB-first,
// repeated a programmable number of times with GAP idle cycles in between.
// Every output is a register; nothing is combinational from the inputs.
module seq_pattern_tx #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
    parameter int               GAP     = 1,
    parameter int               CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_pattern_tx_if.slave    bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int BW = $clog2(PAT_W);
    // Sized so that the counter is at least one bit wide even when GAP is 0.
    localparam int GW = $clog2(GAP + 2);

    localparam logic [BW-1:0] BIT_MSB = BW'(PAT_W - 1);

    logic [1:0]       r_state;
    logic [PAT_W-1:0] r_pat;
    logic [BW-1:0]    r_bit;
    logic [CNT_W-1:0] r_reps;
    logic [GW-1:0]    r_gap;
    logic             r_out;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_frame_end;
    logic             r_done;

    logic             w_start_ok;
    logic [PAT_W-1:0] w_next_pat;

    // A start is taken only with a non-zero count, and abort overrides it.
    assign w_start_ok = bus.start && (bus.reps != '0) && !bus.abort;
    // A same-cycle load_pat supplies the pattern for the burst being started.
    assign w_next_pat = bus.load_pat ? bus.pat_in : r_pat;

    // Burst sequencer: state, counters, pattern register and registered outputs.
    // NOTE: every register here, the pattern register included, is reset and updated with <= so all bits move together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pat       <= PATTERN;
            r_bit       <= '0;
            r_reps      <= '0;
            r_gap       <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_end <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_frame_end <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_out       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    if (bus.load_pat) begin
                        r_pat <= bus.pat_in;
                    end
                    if (w_start_ok) begin
                        r_state     <= S_SEND;
                        r_reps      <= bus.reps;
                        r_bit       <= BIT_MSB;
                        r_out       <= w_next_pat[PAT_W-1];
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (bus.abort) begin
                        r_state     <= S_IDLE;
                        r_reps      <= '0;
                        r_bit       <= '0;
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (r_bit != '0) begin
                        r_bit       <= r_bit - 1'b1;
                        r_out       <= r_pat[r_bit - 1'b1];
                        r_frame_end <= (r_bit == BW'(1));
                    end else if (r_reps == CNT_W'(1)) begin
                        // Final frame complete: done is the only output left high.
                        r_state     <= S_IDLE;
                        r_reps      <= '0;
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_reps <= r_reps - 1'b1;
                        if (GAP > 0) begin
                            r_state     <= S_GAP;
                            r_gap       <= GW'(GAP - 1);
                            r_out       <= 1'b0;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_bit <= BIT_MSB;
                            r_out <= r_pat[PAT_W-1];
                        end
                    end
                end
                S_GAP: begin
                    if (bus.abort) begin
                        r_state     <= S_IDLE;
                        r_reps      <= '0;
                        r_bit       <= '0;
                        r_gap       <= '0;
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (r_gap == '0) begin
                        r_state     <= S_SEND;
                        r_bit       <= BIT_MSB;
                        r_out       <= r_pat[PAT_W-1];
                        r_out_valid <= 1'b1;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.frame_end = r_frame_end;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a GAP=1 build driven from a
// vector table, and a GAP=0 build exercised by hand-written sequences.
module tb_seq_pattern_tx;
    logic clk;
    logic rst;

    int n_cmp = 0;
    int n_err = 0;

    seq_pattern_tx_if #(.PAT_W(4), .CNT_W(8)) if1 ();
    seq_pattern_tx_if #(.PAT_W(4), .CNT_W(8)) if0 ();

    seq_pattern_tx #(.PAT_W(4), .PATTERN(4'b1001), .GAP(1), .CNT_W(8)) u_dut_gap1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    seq_pattern_tx #(.PAT_W(4), .PATTERN(4'b1001), .GAP(0), .CNT_W(8)) u_dut_gap0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference overlapping 1001 detector fed from the GAP=0 build's stream.
    logic [2:0] det_sh;
    logic       det_pulse;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_sh    <= '0;
            det_pulse <= 1'b0;
        end else begin
            det_pulse <= 1'b0;
            if (if0.out_valid) begin
                det_sh    <= {det_sh[1:0], if0.out};
                det_pulse <= ({det_sh, if0.out} == 4'b1001);
            end
        end
    end

    typedef struct {
        logic       ld;
        logic [3:0] pin;
        logic       st;
        logic [7:0] reps;
        logic       ab;
        logic [4:0] exp;   // {out, out_valid, busy, frame_end, done}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ld, logic [3:0] pin, logic st, logic [7:0] reps,
                                logic ab, logic [4:0] exp);
        vec_t v;
        v.ld = ld; v.pin = pin; v.st = st; v.reps = reps; v.ab = ab; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] outs1();
        return {if1.out, if1.out_valid, if1.busy, if1.frame_end, if1.done};
    endfunction

    function automatic logic [4:0] outs0();
        return {if0.out, if0.out_valid, if0.busy, if0.frame_end, if0.done};
    endfunction

    task automatic idle_inputs();
        if1.load_pat = 0; if1.pat_in = '0; if1.start = 0; if1.reps = '0; if1.abort = 0;
        if0.load_pat = 0; if0.pat_in = '0; if0.start = 0; if0.reps = '0; if0.abort = 0;
    endtask

    initial begin
        logic [7:0] exp_bits;
        int fe_cnt, done_cnt, gap_cnt, pulse_cnt;
        logic fe_prev;

        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        check("reset_gap1_outputs", 32'(outs1()), 32'h0);
        check("reset_gap0_outputs", 32'(outs0()), 32'h0);
        rst = 1'b1;
        tick();
        check("post_reset_idle", 32'(outs1()), 32'h0);

        // ---- Vector table on the GAP=1 build ----
        // start with reps=0 is ignored
        tbl.push_back(mk(0, 4'h0, 1, 8'd0, 0, 5'b00000));
        // single frame of the reset pattern 1001, then done
        tbl.push_back(mk(0, 4'h0, 1, 8'd1, 0, 5'b11100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b01100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b01100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b11110));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b00001));
        // start accepted in the done cycle
        tbl.push_back(mk(0, 4'h0, 1, 8'd1, 0, 5'b11100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b01100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b01100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b11110));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b00001));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b00000));
        // reps=3 with one gap cycle; start/load_pat while busy are ignored
        tbl.push_back(mk(0, 4'h0, 1, 8'd3, 0, 5'b11100));
        tbl.push_back(mk(0, 4'h0, 1, 8'd5, 0, 5'b01100));
        tbl.push_back(mk(1, 4'h0, 0, 8'd0, 0, 5'b01100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b11110));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b00100));
        tbl.push_back(mk(0, 4'h0, 1, 8'd1, 0, 5'b11100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b01100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b01100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b11110));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b00100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b11100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b01100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b01100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b11110));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b00001));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b00000));
        // abort on the 2nd bit of a reps=2 burst: no done afterwards
        tbl.push_back(mk(0, 4'h0, 1, 8'd2, 0, 5'b11100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b01100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 1, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b00000));
        // abort beats start in IDLE
        tbl.push_back(mk(0, 4'h0, 1, 8'd1, 1, 5'b00000));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b00000));
        // fresh start: pattern still 1001 despite the earlier busy load_pat
        tbl.push_back(mk(0, 4'h0, 1, 8'd1, 0, 5'b11100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b01100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b01100));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b11110));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b00001));
        tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 5'b00000));

        foreach (tbl[i]) begin
            if1.load_pat = tbl[i].ld;
            if1.pat_in   = tbl[i].pin;
            if1.start    = tbl[i].st;
            if1.reps     = tbl[i].reps;
            if1.abort    = tbl[i].ab;
            tick();
            check($sformatf("vec%0d", i), 32'(outs1()), 32'(tbl[i].exp));
        end
        idle_inputs();

        // ---- Asynchronous reset mid-frame after loading 0110 ----
        if1.load_pat = 1; if1.pat_in = 4'b0110;
        tick();
        if1.load_pat = 0; if1.start = 1; if1.reps = 8'd2;
        tick();
        check("rst_pre_bit3", 32'(outs1()), 32'(5'b01100));
        if1.start = 0;
        tick();
        check("rst_pre_bit2", 32'(outs1()), 32'(5'b11100));
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_clear", 32'(outs1()), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("rst_release_idle", 32'(outs1()), 32'h0);
        if1.start = 1; if1.reps = 8'd1;
        exp_bits = 8'b0000_1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            if1.start = 0;
            check($sformatf("rst_after_bit%0d", i), 32'(outs1()),
                  32'({exp_bits[3-i], 1'b1, 1'b1, (i == 3), 1'b0}));
        end
        tick();
        check("rst_after_done", 32'(outs1()), 32'(5'b00001));

        // ---- GAP=0 build: load 1101, then reps=2 back-to-back ----
        if0.load_pat = 1; if0.pat_in = 4'b1101;
        tick();
        check("g0_load_idle", 32'(outs0()), 32'h0);
        if0.load_pat = 0; if0.start = 1; if0.reps = 8'd2;
        exp_bits = 8'b1101_1101;
        for (int i = 0; i < 8; i++) begin
            tick();
            if0.start = 0;
            check($sformatf("g0_bit%0d", i), 32'(outs0()),
                  32'({exp_bits[7-i], 1'b1, 1'b1, (i % 4 == 3), 1'b0}));
        end
        tick();
        check("g0_done", 32'(outs0()), 32'(5'b00001));
        tick();

        // ---- Maximum count: 255 frames, never wraps ----
        fe_cnt = 0; done_cnt = 0; gap_cnt = 0;
        if0.start = 1; if0.reps = 8'd255;
        for (int n = 0; n < 1024; n++) begin
            tick();
            if0.start = 0;
            if (if0.frame_end) fe_cnt++;
            if (if0.done) done_cnt++;
            if (n < 1020 && !if0.out_valid) gap_cnt++;
        end
        check("max_reps_frames", 32'(fe_cnt), 32'd255);
        check("max_reps_done", 32'(done_cnt), 32'd1);
        check("max_reps_no_bubble", 32'(gap_cnt), 32'd0);
        check("max_reps_idle_after", 32'(outs0()), 32'h0);

        // ---- Loopback into the 1001 detector: 10011001 ----
        if0.load_pat = 1; if0.pat_in = 4'b1001;
        tick();
        if0.load_pat = 0; if0.start = 1; if0.reps = 8'd2;
        fe_prev = 1'b0; pulse_cnt = 0;
        exp_bits = 8'b1001_1001;
        for (int i = 0; i < 11; i++) begin
            tick();
            if0.start = 0;
            if (i < 8) begin
                check($sformatf("loop_bit%0d", i), 32'({if0.out, if0.out_valid}),
                      32'({exp_bits[7-i], 1'b1}));
            end
            check($sformatf("loop_det%0d", i), 32'(det_pulse), 32'(fe_prev));
            if (det_pulse) pulse_cnt++;
            fe_prev = if0.frame_end;
        end
        check("loop_pulse_count", 32'(pulse_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the generating end of the serial bit-pattern detectors in the pulse_generation family (e.g. the overlapping 1001 detector).
- Shifts a PAT_W-bit pattern out MSB-first, one bit per clock, repeated a programmable number of times with a fixed idle gap between repetitions.
- Drives detector stimulus in benches and on-chip self-test paths.
- Emits per-frame and end-of-burst strobes so the receiving detector's pulses can be checked cycle-for-cycle.

Parameters:
- PAT_W, 4, pattern width in bits (≥2)
- PATTERN, 4'b1001, pattern register value after reset
- GAP, 1, idle cycles between repetitions (0 = back-to-back)
- CNT_W, 8, width of repetition count

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- load_pat  input  1  write pat_in into pattern register (honoured only in IDLE)
- pat_in  input  PAT_W  new pattern value
- start  input  1  begin burst (honoured only in IDLE)
- reps  input  CNT_W  repetitions for this burst, sampled with start
- abort  input  1  terminate burst immediately
- out  output  1  serial data bit, MSB of pattern first
- out_valid  output  1  high while out carries a pattern bit
- busy  output  1  high in SEND or GAP
- frame_end  output  1  high with the last bit of each repetition
- done  output  1  one-cycle pulse after the final bit of a completed burst

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE
  - out, out_valid, busy, frame_end, done all 0
  - pattern register=PATTERN
  - repetition and bit counters cleared
- All outputs are registered; none are combinational from inputs.
- States: IDLE, SEND, GAP.
- IDLE:
  - out=0, out_valid=0.
  - load_pat=1 writes pat_in to the pattern register.
  - start=1 with reps≠0 moves to SEND at the same edge. out=pattern[PAT_W-1] and out_valid=1 are visible the cycle after start is sampled (latency 1).
  - start with reps=0 is ignored; no done pulse.
  - load_pat and start together: the new pat_in is used for this burst.
- SEND:
  - Each cycle presents the next bit, PAT_W-1 down to 0.
  - frame_end=1 coincides with bit 0.
  - After bit 0 with repetitions remaining:
    - GAP>0: go to GAP.
    - GAP=0: reload and present the MSB on the very next cycle, with no bubble.
  - After bit 0 of the final repetition:
    - go to IDLE
    - done=1 for exactly the following cycle, with out_valid=0 and busy=0
    - start is accepted in that same cycle
- GAP:
  - Lasts exactly GAP cycles; out=0, out_valid=0, busy=1.
  - Then returns to SEND with the MSB.
- Pattern and reps are latched at start. load_pat, pat_in, reps and start are ignored while busy.
- abort=1 in SEND or GAP:
  - next cycle state=IDLE and all outputs 0
  - no done, no frame_end
  - abort beats start when both are asserted in IDLE; abort in IDLE has no effect.
- Reps counter decrements once per completed frame and never wraps. reps=2^CNT_W-1 transmits that many frames.
- Reset asserted mid-burst clears everything asynchronously, including the pattern register. After release the block waits in IDLE for a new start.
- Total burst length: reps*PAT_W + (reps-1)*GAP cycles from first valid bit to last.

Test Plan:
1. Default pattern, start with reps=1 → out=1,0,0,1 with out_valid=1 for 4 cycles; frame_end on the 4th; done=1 on the 5th; busy=0 on the 5th.
2. reps=3, GAP=1 → out/out_valid sequence 1001,(0/invalid),1001,(0/invalid),1001; 14 cycles; 3 frame_end pulses; 1 done.
3. load_pat with pat_in=4'b1101, then start with reps=2 in a GAP=0 build → 11011101 contiguous, out_valid never drops.
4. start with reps=0; start while busy; load_pat while busy → no output change, no done; current burst and pattern unaffected.
5. abort on the 2nd bit of reps=2 → next cycle out=0, out_valid=0, busy=0; done never asserts. A fresh start then transmits normally.
6. rst=0 mid-frame after load_pat 4'b0110 → outputs 0 immediately, without a clock edge. After release, start with reps=1 transmits 1001.
7. Loopback into the 1001 overlapping detector, pattern 4'b1001, reps=2, GAP=0 → stream 10011001. Detector pulses align with both frame_end cycles (the fixed detector latency applies); no pulse at the inter-frame overlap other than at "1001".
